// File: rtl/fact_initiator.sv
// Bus-side initiator for the memory-mapped factorial accelerator: writes n and go, polls status, reads the result.
// Optional poll timeout is enabled by defining FACT_TIMEOUT_EN (adds the TIMEOUT parameter and a 16-bit poll counter).
module fact_initiator #(
  parameter int N_MAX = 12
`ifdef FACT_TIMEOUT_EN
  , parameter int TIMEOUT = 1024
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [3:0]  req_n,
  output logic        req_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_err,
  output logic [1:0]  A,
  output logic        WE,
  output logic [31:0] WD,
  input  logic [31:0] RD
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR_N   = 3'd1,
    WR_GO  = 3'd2,
    CLR_GO = 3'd3,
    POLL   = 3'd4,
    RD_RES = 3'd5,
    RESP   = 3'd6
  } state_t;

  localparam logic [31:0] N_MAX_U = 32'(N_MAX);

  state_t state;

`ifdef FACT_TIMEOUT_EN
  localparam logic [15:0] POLL_LAST = 16'(TIMEOUT - 1);
  logic [15:0] poll_cnt;
`endif

  // Single FSM; every bus and response output is registered alongside the state that owns it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_result <= 32'd0;
      rsp_err    <= 1'b0;
      A          <= 2'b00;
      WE         <= 1'b0;
      WD         <= 32'd0;
`ifdef FACT_TIMEOUT_EN
      poll_cnt   <= 16'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            // Operands beyond N_MAX would overflow 32 bits, so reject without touching the bus.
            if ({28'd0, req_n} > N_MAX_U) begin
              state      <= RESP;
              rsp_valid  <= 1'b1;
              rsp_err    <= 1'b1;
              rsp_result <= 32'd0;
            end else begin
              state <= WR_N;
              A     <= 2'b00;
              WE    <= 1'b1;
              WD    <= {28'd0, req_n};
            end
          end
        end
        WR_N: begin
          state <= WR_GO;
          A     <= 2'b01;
          WE    <= 1'b1;
          WD    <= 32'd1;
        end
        WR_GO: begin
          state <= CLR_GO;
          A     <= 2'b01;
          WE    <= 1'b1;
          WD    <= 32'd0;
        end
        CLR_GO: begin
          state <= POLL;
          A     <= 2'b10;
          WE    <= 1'b0;
          WD    <= 32'd0;
`ifdef FACT_TIMEOUT_EN
          poll_cnt <= 16'd0;
`endif
        end
        POLL: begin
          // Error wins over done when both status bits are set.
          if (RD[1]) begin
            state      <= RESP;
            A          <= 2'b00;
            rsp_valid  <= 1'b1;
            rsp_err    <= 1'b1;
            rsp_result <= 32'd0;
          end else if (RD[0]) begin
            state <= RD_RES;
            A     <= 2'b11;
          end
`ifdef FACT_TIMEOUT_EN
          else if (poll_cnt == POLL_LAST) begin
            state      <= RESP;
            A          <= 2'b00;
            rsp_valid  <= 1'b1;
            rsp_err    <= 1'b1;
            rsp_result <= 32'd0;
          end else begin
            poll_cnt <= poll_cnt + 16'd1;
          end
`endif
        end
        RD_RES: begin
          state      <= RESP;
          A          <= 2'b00;
          rsp_valid  <= 1'b1;
          rsp_err    <= 1'b0;
          rsp_result <= RD;
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          A         <= 2'b00;
          WE        <= 1'b0;
          WD        <= 32'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fact_initiator.sv
// Self-checking bench for fact_initiator: accelerator register model, vector table, scoreboard queue and corner-case sequences.
module tb_fact_initiator;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic [3:0]  req_n;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_err;
  logic [1:0]  A;
  logic        WE;
  logic [31:0] WD;
  logic [31:0] RD;

  fact_initiator dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_n(req_n), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_err(rsp_err),
    .A(A), .WE(WE), .WD(WD), .RD(RD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Accelerator model: registers n and go, status raised on the done_at-th poll cycle.
  logic [3:0] acc_n;
  logic       acc_go;
  int         polls;
  int         done_at;
  logic       err_mode;
  logic       never;
  logic       hit;

  function automatic logic [31:0] acc_fact(input logic [3:0] n);
    logic [31:0] p;
    p = 32'd1;
    for (int i = 2; i <= 15; i++)
      if (i <= int'(n)) p = p * 32'(i);
    return p;
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      acc_n  <= 4'd0;
      acc_go <= 1'b0;
      polls  <= 0;
    end else begin
      if (WE && A == 2'b00) acc_n <= WD[3:0];
      if (WE && A == 2'b01) begin
        acc_go <= WD[0];
        if (WD[0]) polls <= 0;
      end else if (A == 2'b10) begin
        polls <= polls + 1;
      end
    end
  end

  always_comb begin
    hit = !never && (polls >= done_at - 1);
    case (A)
      2'b00:   RD = {28'd0, acc_n};
      2'b01:   RD = {31'd0, acc_go};
      2'b10:   RD = {30'd0, err_mode && hit, hit};
      default: RD = acc_fact(acc_n);
    endcase
  end

  typedef struct {
    logic [3:0]  n;
    int          done_at;
    logic        err_mode;
    int          hold;
    logic [31:0] res;
    logic        err;
    int          lat;
    int          we;
  } vec_t;

  typedef struct packed {
    logic [31:0] res;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[10];

  task automatic accept_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    check("after_accept {rsp_valid,req_ready}", {30'd0, rsp_valid, req_ready}, 32'd1);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int   cyc;
    int   we_cnt;
    logic saw_a3;
    logic bus_ok;
    logic rdy_ok;
    exp_t e;
    logic [31:0] r0;
    logic        e0;
    done_at  = v.done_at;
    err_mode = v.err_mode;
    never    = 1'b0;
    check($sformatf("v%0d req_ready_idle", idx), {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_n     = v.n;
    exp_q.push_back('{res: v.res, err: v.err});
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_n = 4'($urandom_range(15));
    we_cnt = 0; saw_a3 = 1'b0; bus_ok = 1'b1; rdy_ok = 1'b1;
    for (cyc = 1; cyc <= 2000; cyc++) begin
      @(negedge clk);
      if (rsp_valid) break;
      if (WE) we_cnt++;
      if (A == 2'b11) saw_a3 = 1'b1;
      if (req_ready) rdy_ok = 1'b0;
      if (cyc == 1 && {A, WE, WD} !== {2'b00, 1'b1, 28'd0, v.n}) bus_ok = 1'b0;
      if (cyc == 2 && {A, WE, WD} !== {2'b01, 1'b1, 32'd1}) bus_ok = 1'b0;
      if (cyc == 3 && {A, WE, WD} !== {2'b01, 1'b1, 32'd0}) bus_ok = 1'b0;
      if (cyc >= 4 && WE) bus_ok = 1'b0;
    end
    check($sformatf("v%0d latency", idx), 32'(cyc), 32'(v.lat));
    check($sformatf("v%0d we_cycles", idx), 32'(we_cnt), 32'(v.we));
    check($sformatf("v%0d bus_sequence", idx), {31'd0, bus_ok}, 32'd1);
    check($sformatf("v%0d busy_not_ready", idx), {31'd0, rdy_ok}, 32'd1);
    check($sformatf("v%0d result_read", idx), {31'd0, saw_a3}, {31'd0, (v.we == 3) && !v.err});
    if (exp_q.size() == 0) begin
      check($sformatf("v%0d scoreboard_empty", idx), 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("v%0d rsp_result", idx), rsp_result, e.res);
      check($sformatf("v%0d rsp_err", idx), {31'd0, rsp_err}, {31'd0, e.err});
    end
    r0 = rsp_result;
    e0 = rsp_err;
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      check($sformatf("v%0d bp_result", idx), rsp_result, r0);
      check($sformatf("v%0d bp_{valid,ready,err}", idx), {29'd0, rsp_valid, req_ready, rsp_err}, {29'd0, 1'b1, 1'b0, e0});
    end
    accept_rsp();
  endtask

  initial begin
    int cyc;
    int stray;
    int poll_seen;
    logic seen_valid;
    reset = 1'b0; req_valid = 1'b0; req_n = 4'd0; rsp_ready = 1'b0;
    never = 1'b0; done_at = 1; err_mode = 1'b0;

    vecs[0] = '{4'd5,  3, 1'b0, 0, 32'd120,       1'b0, 8, 3};
    vecs[1] = '{4'd13, 1, 1'b0, 0, 32'd0,         1'b1, 1, 0};
    vecs[2] = '{4'd0,  1, 1'b0, 0, 32'd1,         1'b0, 6, 3};
    vecs[3] = '{4'd12, 2, 1'b0, 0, 32'd479001600, 1'b0, 7, 3};
    vecs[4] = '{4'd7,  1, 1'b1, 0, 32'd0,         1'b1, 5, 3};
    vecs[5] = '{4'd15, 1, 1'b0, 2, 32'd0,         1'b1, 1, 0};
    vecs[6] = '{4'd10, 4, 1'b0, 0, 32'd3628800,   1'b0, 9, 3};
    vecs[7] = '{4'd4,  2, 1'b0, 4, 32'd24,        1'b0, 7, 3};
    vecs[8] = '{4'd3,  5, 1'b1, 0, 32'd0,         1'b1, 9, 3};
    vecs[9] = '{4'd1,  1, 1'b0, 0, 32'd1,         1'b0, 6, 3};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset req_ready", {31'd0, req_ready}, 32'd1);
    check("reset {rsp_valid,rsp_err,WE,A}", {27'd0, rsp_valid, rsp_err, WE, A}, 32'd0);
    check("reset rsp_result", rsp_result, 32'd0);
    check("reset WD", WD, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Reset while polling: bus goes quiet and the pending result never appears.
    done_at = 3; err_mode = 1'b0; never = 1'b0;
    req_valid = 1'b1; req_n = 4'd6;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("mid A in poll", {30'd0, A}, 32'd2);
    reset = 1'b0;
    @(negedge clk);
    check("mid_reset req_ready", {31'd0, req_ready}, 32'd1);
    check("mid_reset {rsp_valid,rsp_err,WE,A}", {27'd0, rsp_valid, rsp_err, WE, A}, 32'd0);
    check("mid_reset rsp_result", rsp_result, 32'd0);
    reset = 1'b1;
    stray = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid || WE || !req_ready) stray++;
    end
    check("post_reset quiet", 32'(stray), 32'd0);

    // Accelerator that never finishes.
    never = 1'b1; done_at = 1; err_mode = 1'b0;
    req_valid = 1'b1; req_n = 4'd2;
    @(posedge clk);
    #1 req_valid = 1'b0;
    poll_seen = 0; seen_valid = 1'b0;
`ifdef FACT_TIMEOUT_EN
    for (cyc = 1; cyc <= 1200; cyc++) begin
      @(negedge clk);
      if (rsp_valid) break;
      if (A == 2'b10) poll_seen++;
    end
    check("timeout latency", 32'(cyc), 32'd1028);
    check("timeout poll cycles", 32'(poll_seen), 32'd1024);
    check("timeout rsp_err", {31'd0, rsp_err}, 32'd1);
    check("timeout rsp_result", rsp_result, 32'd0);
`else
    for (cyc = 1; cyc <= 1100; cyc++) begin
      @(negedge clk);
      if (rsp_valid) seen_valid = 1'b1;
      if (A == 2'b10) poll_seen++;
    end
    check("wait no response", {31'd0, seen_valid}, 32'd0);
    check("wait poll cycles", 32'(poll_seen), 32'd1097);
    never = 1'b0;
    for (cyc = 1101; cyc <= 1120; cyc++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    check("late done latency", 32'(cyc), 32'd1102);
    check("late done rsp_result", rsp_result, 32'd2);
    check("late done rsp_err", {31'd0, rsp_err}, 32'd0);
`endif
    accept_rsp();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
